// File: rtl/io_input_conditioner_if.sv
// Switch-port bundle between the FPGA pins and the conditioned io_in path.
// IO_CHANGE_FLAG_EN adds the sticky change flag and its clear.
interface io_input_conditioner_if #(
    parameter int unsigned WIDTH = 10
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_out;
    logic             sw_changed;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
`ifdef IO_CHANGE_FLAG_EN
    logic             chg_clr;
    logic             chg_flag;

    modport master (
        output sw_raw,
        output chg_clr,
        input  sw_out,
        input  sw_changed,
        input  sw_rise,
        input  sw_fall,
        input  chg_flag
    );

    modport slave (
        input  sw_raw,
        input  chg_clr,
        output sw_out,
        output sw_changed,
        output sw_rise,
        output sw_fall,
        output chg_flag
    );
`else
    modport master (
        output sw_raw,
        input  sw_out,
        input  sw_changed,
        input  sw_rise,
        input  sw_fall
    );

    modport slave (
        input  sw_raw,
        output sw_out,
        output sw_changed,
        output sw_rise,
        output sw_fall
    );
`endif
endinterface

// File: rtl/io_input_conditioner.sv
// Two-flop synchroniser plus per-bit debounce for the switch port, with registered edge strobes.
// Optional sticky change flag (chg_flag / chg_clr) is built when IO_CHANGE_FLAG_EN is defined.
module io_input_conditioner #(
    parameter int unsigned WIDTH           = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input logic              clock,
    input logic              resetn,
    io_input_conditioner_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q, changed_d;
    logic [WIDTH-1:0] accept;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.sw_raw;
            sync2_q <= sync1_q;
        end
    end

    // Counter only advances while sync2 disagrees with the accepted value; a single
    // agreeing cycle restarts it, and acceptance clears it so it never wraps.
    always_comb begin
        stable_d = stable_q;
        accept   = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    accept[i]   = 1'b1;
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        rise_d    = accept & sync2_q;
        fall_d    = accept & ~sync2_q;
        changed_d = |accept;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stable_q  <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q  <= stable_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.sw_out     = stable_q;
    assign bus.sw_rise    = rise_q;
    assign bus.sw_fall    = fall_q;
    assign bus.sw_changed = changed_q;

`ifdef IO_CHANGE_FLAG_EN
    logic flag_q;

    // Set takes priority so a change landing on the clear cycle is not lost.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            flag_q <= 1'b0;
        end else if (changed_q) begin
            flag_q <= 1'b1;
        end else if (bus.chg_clr) begin
            flag_q <= 1'b0;
        end
    end

    assign bus.chg_flag = flag_q;
`endif

endmodule

// File: tb/tb_io_input_conditioner.sv
// Scoreboard bench for io_input_conditioner with DEBOUNCE_CYCLES=4; build with IO_CHANGE_FLAG_EN
// defined to also exercise the sticky change flag.
module tb_io_input_conditioner;
    localparam int unsigned WIDTH = 10;
    localparam int unsigned DEB   = 4;
    localparam int          LAT   = DEB + 2;

    typedef struct {
        int               edge_no;
        logic [WIDTH-1:0] out;
        logic [WIDTH-1:0] rise;
        logic [WIDTH-1:0] fall;
    } exp_t;

    logic             clock = 1'b0;
    logic             resetn;
    int               cyc = 0;
    int               n_checks = 0;
    int               n_fail = 0;
    exp_t             exp_q[$];
    logic [WIDTH-1:0] exp_out = '0;
    logic [WIDTH-1:0] model_out = '0;
    exp_t             m_e;
    logic [WIDTH-1:0] m_out, m_rise, m_fall;
    logic             m_chg;

    always #5 clock = ~clock;

    io_input_conditioner_if #(.WIDTH(WIDTH)) bus ();

    io_input_conditioner #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (16)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    always @(posedge clock) cyc <= cyc + 1;

    // Every cycle out of reset, outputs must match the scoreboard: either the queued
    // acceptance event for this edge, or a quiet cycle holding the last accepted value.
    always @(posedge clock) begin
        #1;
        if (!resetn) begin
            exp_out = '0;
        end else begin
            m_out  = exp_out;
            m_rise = '0;
            m_fall = '0;
            m_chg  = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].edge_no == cyc) begin
                m_e     = exp_q.pop_front();
                m_out   = m_e.out;
                m_rise  = m_e.rise;
                m_fall  = m_e.fall;
                m_chg   = 1'b1;
                exp_out = m_e.out;
            end
            n_checks++;
            if (bus.sw_out !== m_out || bus.sw_rise !== m_rise || bus.sw_fall !== m_fall ||
                bus.sw_changed !== m_chg) begin
                n_fail++;
                $display("FAIL scoreboard edge %0d: got out=%h rise=%h fall=%h chg=%b, want out=%h rise=%h fall=%h chg=%b",
                         cyc, bus.sw_out, bus.sw_rise, bus.sw_fall, bus.sw_changed,
                         m_out, m_rise, m_fall, m_chg);
            end
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Drive a settled pin value and queue the acceptance it must cause LAT edges later.
    task automatic drive(input logic [WIDTH-1:0] v);
        bus.sw_raw = v;
        if (v !== model_out) begin
            exp_q.push_back('{edge_no: cyc + LAT, out: v, rise: v & ~model_out,
                              fall: model_out & ~v});
        end
        model_out = v;
    endtask

    task automatic test_reset;
        resetn     = 1'b0;
        bus.sw_raw = '1;
`ifdef IO_CHANGE_FLAG_EN
        bus.chg_clr = 1'b0;
`endif
        wait_edges(3);
        n_checks++;
        if (bus.sw_out !== '0 || bus.sw_rise !== '0 || bus.sw_fall !== '0 ||
            bus.sw_changed !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: got out=%h rise=%h fall=%h chg=%b, want all 0",
                     bus.sw_out, bus.sw_rise, bus.sw_fall, bus.sw_changed);
        end
        resetn    = 1'b1;
        model_out = '0;
        drive(10'h3FF);
        wait_edges(LAT + 3);
        n_checks++;
        if (bus.sw_out !== 10'h3FF) begin
            n_fail++;
            $display("FAIL reset_release: got out=%h, want 3ff", bus.sw_out);
        end
    endtask

    task automatic test_clean_change;
        drive(10'h000);
        wait_edges(LAT + 2);
        drive(10'h008);
        wait_edges(LAT + 2);
        n_checks++;
        if (bus.sw_out !== 10'h008) begin
            n_fail++;
            $display("FAIL clean_change: got out=%h, want 008", bus.sw_out);
        end
    endtask

    task automatic test_glitch;
        drive(10'h000);
        wait_edges(LAT + 2);
        bus.sw_raw = 10'h001;
        wait_edges(3);
        bus.sw_raw = 10'h000;
        wait_edges(LAT + 3);
        n_checks++;
        if (bus.sw_out !== 10'h000) begin
            n_fail++;
            $display("FAIL glitch: got out=%h, want 000", bus.sw_out);
        end
    endtask

    task automatic test_bounce;
        logic [WIDTH-1:0] v;
        for (int k = 0; k < 5; k++) begin
            v    = 10'h000;
            v[5] = (k % 2 == 0);
            if (k == 4) drive(v);
            else bus.sw_raw = v;
            wait_edges(1);
        end
        wait_edges(LAT + 2);
        n_checks++;
        if (bus.sw_out !== 10'h020) begin
            n_fail++;
            $display("FAIL bounce: got out=%h, want 020", bus.sw_out);
        end
    endtask

    task automatic test_multi_bit_fall;
        drive(10'h00F);
        wait_edges(LAT + 2);
        drive(10'h0F0);
        wait_edges(LAT + 2);
        n_checks++;
        if (bus.sw_out !== 10'h0F0) begin
            n_fail++;
            $display("FAIL multi_bit: got out=%h, want 0f0", bus.sw_out);
        end
    endtask

    task automatic test_reset_midcount;
        bus.sw_raw = 10'h3FF;
        wait_edges(4);
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (bus.sw_out !== '0 || bus.sw_rise !== '0 || bus.sw_fall !== '0 ||
            bus.sw_changed !== 1'b0) begin
            n_fail++;
            $display("FAIL midcount_reset: got out=%h rise=%h fall=%h chg=%b, want all 0",
                     bus.sw_out, bus.sw_rise, bus.sw_fall, bus.sw_changed);
        end
`ifdef IO_CHANGE_FLAG_EN
        n_checks++;
        if (bus.chg_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL midcount_reset_flag: got %b, want 0", bus.chg_flag);
        end
`endif
        exp_q.delete();
        model_out = '0;
        wait_edges(2);
        resetn = 1'b1;
        drive(10'h3FF);
`ifdef IO_CHANGE_FLAG_EN
        bus.chg_clr = 1'b1;
        wait_edges(LAT + 1);
        n_checks++;
        if (bus.chg_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL flag_set_wins: got %b, want 1", bus.chg_flag);
        end
        wait_edges(1);
        n_checks++;
        if (bus.chg_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL flag_clear: got %b, want 0", bus.chg_flag);
        end
        bus.chg_clr = 1'b0;
`else
        wait_edges(LAT + 2);
`endif
        wait_edges(2);
        n_checks++;
        if (bus.sw_out !== 10'h3FF) begin
            n_fail++;
            $display("FAIL midcount_reaccept: got out=%h, want 3ff", bus.sw_out);
        end
    endtask

    initial begin
        test_reset();
        test_clean_change();
        test_glitch();
        test_bounce();
        test_multi_bit_fall();
        test_reset_midcount();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
